uart_tx_sequencer: RTL and testbench

Frame-level controller for the UART transmit path. It paces frames on the baud tick, pops one byte per frame from the TX FIFO, and drives the one-hot frame state and bit index consumed by the TX shift register and parity generator. Per-frame settings (data length, parity, stop bits) are latched at frame start, so mid-frame config writes never corrupt a frame.

---
 rtl/uart_tx_sequencer.sv | 131 +++++++++++++
 tb/tb_uart_tx_sequencer.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sequencer.sv
// rtl/uart_tx_sequencer.sv - UART transmit frame sequencer: baud pacing, FIFO pop, one-hot frame state
module uart_tx_sequencer #(
    parameter int unsigned IDLE_BAUDS  = 1,
    parameter int unsigned FRAME_CNT_W = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   baud_tick_i,
    input  logic                   enable_i,
    input  logic [1:0]             cfg_data_bits_i,
    input  logic                   cfg_parity_en_i,
    input  logic                   cfg_stop2_i,
    input  logic                   fifo_empty_i,
    output logic                   fifo_re_n_o,
    output logic [4:0]             state_o,
    output logic [3:0]             bit_cnt_o,
    output logic                   busy_o,
    output logic                   tx_done_o,
    output logic [FRAME_CNT_W-1:0] frame_cnt_o
);

    localparam logic [4:0] S_INTERVAL  = 5'b00001;
    localparam logic [4:0] S_STARTBIT  = 5'b00010;
    localparam logic [4:0] S_DATABITS  = 5'b00100;
    localparam logic [4:0] S_PARITYBIT = 5'b01000;
    localparam logic [4:0] S_STOPBIT   = 5'b10000;

    localparam logic [3:0]             IDLE_MAX  = 4'(IDLE_BAUDS);
    localparam logic [FRAME_CNT_W-1:0] FRAME_ONE = FRAME_CNT_W'(1);

    logic [4:0]             state;
    logic [3:0]             bit_cnt;
    logic [3:0]             idle_cnt;
    logic [1:0]             lat_bits;
    logic                   lat_parity;
    logic                   lat_stop2;
    logic                   re_n;
    logic                   done;
    logic [FRAME_CNT_W-1:0] frame_cnt;

    logic idle_ok;
    logic start_ok;
    logic last_data;

    assign idle_ok   = (idle_cnt == IDLE_MAX);
    assign start_ok  = idle_ok & enable_i & ~fifo_empty_i;
    assign last_data = (bit_cnt == ({2'b00, lat_bits} + 4'd4));

    // Frame settings are captured only at the start decision so config writes land on the next frame.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= S_INTERVAL;
            bit_cnt    <= 4'd0;
            idle_cnt   <= IDLE_MAX;
            lat_bits   <= 2'b00;
            lat_parity <= 1'b0;
            lat_stop2  <= 1'b0;
            re_n       <= 1'b1;
            done       <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            re_n <= 1'b1;
            done <= 1'b0;
            case (state)
                S_INTERVAL: begin
                    if (baud_tick_i) begin
                        if (start_ok) begin
                            state      <= S_STARTBIT;
                            bit_cnt    <= 4'd0;
                            re_n       <= 1'b0;
                            lat_bits   <= cfg_data_bits_i;
                            lat_parity <= cfg_parity_en_i;
                            lat_stop2  <= cfg_stop2_i;
                        end else if (!idle_ok) begin
                            idle_cnt <= idle_cnt + 4'd1;
                        end
                    end
                end
                S_STARTBIT: begin
                    if (baud_tick_i) begin
                        state   <= S_DATABITS;
                        bit_cnt <= 4'd0;
                    end
                end
                S_DATABITS: begin
                    if (baud_tick_i) begin
                        if (last_data) begin
                            state   <= lat_parity ? S_PARITYBIT : S_STOPBIT;
                            bit_cnt <= 4'd0;
                        end else begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end
                    end
                end
                S_PARITYBIT: begin
                    if (baud_tick_i) begin
                        state   <= S_STOPBIT;
                        bit_cnt <= 4'd0;
                    end
                end
                S_STOPBIT: begin
                    if (baud_tick_i) begin
                        if (lat_stop2 && (bit_cnt == 4'd0)) begin
                            bit_cnt <= 4'd1;
                        end else begin
                            state     <= S_INTERVAL;
                            bit_cnt   <= 4'd0;
                            idle_cnt  <= 4'd0;
                            done      <= 1'b1;
                            frame_cnt <= frame_cnt + FRAME_ONE;
                        end
                    end
                end
                default: begin
                    // Corrupted one-hot: fall back to idle silently, no pop and no completion.
                    state    <= S_INTERVAL;
                    bit_cnt  <= 4'd0;
                    idle_cnt <= 4'd0;
                end
            endcase
        end
    end

    assign fifo_re_n_o = re_n;
    assign state_o     = state;
    assign bit_cnt_o   = bit_cnt;
    assign busy_o      = (state != S_INTERVAL);
    assign tx_done_o   = done;
    assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_uart_tx_sequencer.sv
// tb/tb_uart_tx_sequencer.sv - self-checking bench for uart_tx_sequencer
module tb_uart_tx_sequencer;

    localparam logic [4:0] T_I = 5'b00001;
    localparam logic [4:0] T_S = 5'b00010;
    localparam logic [4:0] T_D = 5'b00100;
    localparam logic [4:0] T_P = 5'b01000;
    localparam logic [4:0] T_X = 5'b10000;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       baud_tick_i = 1'b0;
    logic       enable_i = 1'b0;
    logic [1:0] cfg_data_bits_i = 2'b00;
    logic       cfg_parity_en_i = 1'b0;
    logic       cfg_stop2_i = 1'b0;
    logic       fifo_empty_i = 1'b1;

    logic        re0, by0, dn0, re3, by3, dn3;
    logic [4:0]  st0, st3;
    logic [3:0]  bc0, bc3;
    logic [15:0] fc0, fc3;

    int total = 0;
    int bad = 0;
    logic chk_en = 1'b0;

    always #5 clk = ~clk;

    uart_tx_sequencer #(.IDLE_BAUDS(1), .FRAME_CNT_W(16)) dut (
        .clk(clk), .rst(rst), .baud_tick_i(baud_tick_i), .enable_i(enable_i),
        .cfg_data_bits_i(cfg_data_bits_i), .cfg_parity_en_i(cfg_parity_en_i),
        .cfg_stop2_i(cfg_stop2_i), .fifo_empty_i(fifo_empty_i), .fifo_re_n_o(re0),
        .state_o(st0), .bit_cnt_o(bc0), .busy_o(by0), .tx_done_o(dn0), .frame_cnt_o(fc0)
    );

    uart_tx_sequencer #(.IDLE_BAUDS(3), .FRAME_CNT_W(16)) dut3 (
        .clk(clk), .rst(rst), .baud_tick_i(baud_tick_i), .enable_i(enable_i),
        .cfg_data_bits_i(cfg_data_bits_i), .cfg_parity_en_i(cfg_parity_en_i),
        .cfg_stop2_i(cfg_stop2_i), .fifo_empty_i(fifo_empty_i), .fifo_re_n_o(re3),
        .state_o(st3), .bit_cnt_o(bc3), .busy_o(by3), .tx_done_o(dn3), .frame_cnt_o(fc3)
    );

    // Reference: a frame is a run of positions 0..len-1 (start, data, parity, stops) after a pop.
    int          ib[2] = '{1, 3};
    logic        m_in[2];
    int          m_pos[2], m_n[2], m_p[2], m_s[2], m_idle[2];
    logic        m_re[2], m_done[2];
    logic [15:0] m_fc[2];

    always @(posedge clk or negedge rst) begin
        for (int i = 0; i < 2; i++) begin
            if (!rst) begin
                m_in[i] = 1'b0; m_pos[i] = 0; m_idle[i] = ib[i];
                m_re[i] = 1'b0; m_done[i] = 1'b0; m_fc[i] = 16'd0;
                m_n[i] = 5; m_p[i] = 0; m_s[i] = 1;
            end else begin
                m_re[i] = 1'b0;
                m_done[i] = 1'b0;
                if (baud_tick_i) begin
                    if (m_in[i]) begin
                        m_pos[i] = m_pos[i] + 1;
                        if (m_pos[i] == 1 + m_n[i] + m_p[i] + m_s[i]) begin
                            m_in[i] = 1'b0; m_done[i] = 1'b1;
                            m_fc[i] = m_fc[i] + 16'd1; m_idle[i] = 0;
                        end
                    end else if (m_idle[i] >= ib[i] && enable_i && !fifo_empty_i) begin
                        m_in[i] = 1'b1; m_pos[i] = 0; m_re[i] = 1'b1;
                        m_n[i] = 5 + int'(cfg_data_bits_i);
                        m_p[i] = cfg_parity_en_i ? 1 : 0;
                        m_s[i] = cfg_stop2_i ? 2 : 1;
                    end else begin
                        m_idle[i] = m_idle[i] + 1;
                    end
                end
            end
        end
    end

    function automatic logic [4:0] m_state(int i);
        if (!m_in[i]) return T_I;
        if (m_pos[i] == 0) return T_S;
        if (m_pos[i] <= m_n[i]) return T_D;
        if (m_p[i] == 1 && m_pos[i] == m_n[i] + 1) return T_P;
        return T_X;
    endfunction

    function automatic logic [3:0] m_bit(int i);
        if (!m_in[i] || m_pos[i] == 0) return 4'd0;
        if (m_pos[i] <= m_n[i]) return 4'(m_pos[i] - 1);
        if (m_p[i] == 1 && m_pos[i] == m_n[i] + 1) return 4'd0;
        return 4'(m_pos[i] - (m_n[i] + 1 + m_p[i]));
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_model(input int i, input logic [4:0] st, input logic [3:0] bc, input logic re_n,
                             input logic done, input logic [15:0] fc, input logic busy);
        total++;
        if (st !== m_state(i) || bc !== m_bit(i) || re_n !== !m_re[i] || done !== m_done[i] ||
            fc !== m_fc[i] || busy !== m_in[i]) begin
            bad++;
            $display("FAIL model%0d t=%0t state=%b/%b bit=%0d/%0d re_n=%b/%b done=%b/%b frames=%0d/%0d busy=%b/%b",
                     i, $time, st, m_state(i), bc, m_bit(i), re_n, !m_re[i], done, m_done[i],
                     fc, m_fc[i], busy, m_in[i]);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en && rst) begin
            chk_model(0, st0, bc0, re0, dn0, fc0, by0);
            chk_model(1, st3, bc3, re3, dn3, fc3, by3);
        end
    end

    logic [4:0] c_st, c3_st;
    logic [3:0] c_bc;
    logic       c_re, c_dn, c3_re, c3_dn;

    task automatic tick();
        baud_tick_i = 1'b1;
        @(posedge clk); #1;
        baud_tick_i = 1'b0;
        c_st = st0; c_bc = bc0; c_re = re0; c_dn = dn0;
        c3_st = st3; c3_re = re3; c3_dn = dn3;
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        baud_tick_i = 1'b0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
    endtask

    task automatic set_cfg(input int bits, input int par, input int st2);
        cfg_data_bits_i = 2'(bits);
        cfg_parity_en_i = (par != 0);
        cfg_stop2_i = (st2 != 0);
    endtask

    typedef struct {
        logic       en;
        logic       empty;
        logic [1:0] bits;
        logic       par;
        logic       st2;
        logic [4:0] st;
        logic [3:0] bc;
        logic       re_n;
        logic       done;
    } vec_t;

    vec_t vt[$];

    task automatic add(input int en, input int empty, input int bits, input int par, input int st2,
                       input logic [4:0] st, input int bc, input int re_n, input int done);
        vec_t v;
        v.en = (en != 0); v.empty = (empty != 0); v.bits = 2'(bits);
        v.par = (par != 0); v.st2 = (st2 != 0); v.st = st; v.bc = 4'(bc);
        v.re_n = (re_n != 0); v.done = (done != 0);
        vt.push_back(v);
    endtask

    int n, fifo_cnt, strobes, ndone, gap;
    logic ok, seen;

    initial begin
        // 8N1 frame, then a back-to-back 5-bit/parity/2-stop frame
        add(1, 0, 3, 0, 0, T_S, 0, 0, 0);
        for (int b = 0; b < 8; b++) add(1, 1, 3, 0, 0, T_D, b, 1, 0);
        add(1, 1, 3, 0, 0, T_X, 0, 1, 0);
        add(1, 1, 3, 0, 0, T_I, 0, 1, 1);
        add(1, 0, 0, 1, 1, T_I, 0, 1, 0);
        add(1, 0, 0, 1, 1, T_S, 0, 0, 0);
        for (int b = 0; b < 5; b++) add(1, 1, 0, 1, 1, T_D, b, 1, 0);
        add(1, 1, 0, 1, 1, T_P, 0, 1, 0);
        add(1, 1, 0, 1, 1, T_X, 0, 1, 0);
        add(1, 1, 0, 1, 1, T_X, 1, 1, 0);
        add(1, 1, 0, 1, 1, T_I, 0, 1, 1);

        do_reset();
        chk_en = 1'b1;
        check("rst_state", 32'(st0), 32'(T_I));
        check("rst_bit", 32'(bc0), 0);
        check("rst_re_n", 32'(re0), 1);
        check("rst_busy", 32'(by0), 0);
        check("rst_done", 32'(dn0), 0);
        check("rst_frames", 32'(fc0), 0);

        for (int k = 0; k < vt.size(); k++) begin
            enable_i = vt[k].en; fifo_empty_i = vt[k].empty;
            cfg_data_bits_i = vt[k].bits; cfg_parity_en_i = vt[k].par; cfg_stop2_i = vt[k].st2;
            tick();
            check($sformatf("vec%0d_state", k), 32'(c_st), 32'(vt[k].st));
            check($sformatf("vec%0d_bit", k), 32'(c_bc), 32'(vt[k].bc));
            check($sformatf("vec%0d_re_n", k), 32'(c_re), 32'(vt[k].re_n));
            check($sformatf("vec%0d_done", k), 32'(c_dn), 32'(vt[k].done));
        end
        check("vec_frames", 32'(fc0), 2);

        // Config rewrite mid-frame must only affect the following frame
        do_reset();
        enable_i = 1'b1; set_cfg(3, 0, 0); fifo_empty_i = 1'b0;
        tick();
        check("cfgchg_start", 32'(c_st), 32'(T_S));
        fifo_empty_i = 1'b1;
        repeat (4) tick();
        check("cfgchg_bit3", 32'(c_bc), 3);
        set_cfg(0, 0, 0);
        n = 4;
        for (int k = 0; k < 20; k++) begin
            tick(); n++;
            if (c_st == T_I) break;
        end
        check("cfgchg_len_first", n, 10);
        tick();
        fifo_empty_i = 1'b0;
        tick();
        fifo_empty_i = 1'b1;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            tick(); n++;
            if (c_st == T_I) break;
        end
        check("cfgchg_len_next", n, 7);

        // IDLE_BAUDS=3 instance draining a two-byte FIFO
        do_reset();
        enable_i = 1'b1; set_cfg(0, 0, 0);
        fifo_cnt = 2; strobes = 0; ndone = 0; gap = 0;
        for (int k = 0; k < 40; k++) begin
            fifo_empty_i = (fifo_cnt == 0);
            tick();
            if (!c3_re) begin fifo_cnt--; strobes++; end
            if (c3_dn) ndone++;
            else if (ndone == 1 && c3_st == T_I) gap++;
        end
        check("idle3_strobes", strobes, 2);
        check("idle3_gap", gap, 3);
        check("idle3_frames", 32'(fc3), 2);

        // enable dropped mid-frame: frame finishes, then holds until re-enabled
        do_reset();
        enable_i = 1'b1; set_cfg(3, 0, 0); fifo_empty_i = 1'b0;
        tick();
        check("en_start_re", 32'(c_re), 0);
        repeat (3) tick();
        check("en_bit2", 32'(c_bc), 2);
        enable_i = 1'b0;
        seen = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (c_dn) begin seen = 1'b1; break; end
        end
        check("en_frame_done", 32'(seen), 1);
        check("en_frames", 32'(fc0), 1);
        ok = 1'b1;
        repeat (5) begin
            tick();
            if (!c_re || c_st != T_I) ok = 1'b0;
        end
        check("en_hold", 32'(ok), 1);
        enable_i = 1'b1;
        tick();
        check("en_restart_state", 32'(c_st), 32'(T_S));
        check("en_restart_re", 32'(c_re), 0);

        // Randomized traffic against the reference
        for (int k = 0; k < 3000; k++) begin
            baud_tick_i = ($urandom_range(0, 2) == 0);
            enable_i = ($urandom_range(0, 9) != 0);
            cfg_data_bits_i = 2'($urandom_range(0, 3));
            cfg_parity_en_i = 1'($urandom_range(0, 1));
            cfg_stop2_i = 1'($urandom_range(0, 1));
            fifo_empty_i = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
        end
        baud_tick_i = 1'b0;

        // Asynchronous reset during the parity bit
        do_reset();
        enable_i = 1'b1; set_cfg(0, 1, 0); fifo_empty_i = 1'b0;
        repeat (7) tick();
        check("arst_in_parity", 32'(c_st), 32'(T_P));
        #2 rst = 1'b0;
        #1;
        check("arst_state", 32'(st0), 32'(T_I));
        check("arst_bit", 32'(bc0), 0);
        check("arst_busy", 32'(by0), 0);
        check("arst_re_n", 32'(re0), 1);
        @(posedge clk); #1 rst = 1'b1;

        // Corrupted state register recovers on the next clock
        chk_en = 1'b0;
        repeat (5) tick();
        check("seu_pre_bit", 32'(c_bc), 3);
        @(negedge clk);
        force dut.state = 5'b00110;
        #1 release dut.state;
        @(posedge clk); #1;
        check("seu_state", 32'(st0), 32'(T_I));
        check("seu_bit", 32'(bc0), 0);
        check("seu_re_n", 32'(re0), 1);
        check("seu_done", 32'(dn0), 0);
        check("seu_busy", 32'(by0), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
